// File: rtl/game_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : game_pkg
// Brief  : shared constants, move codes and move decoder
// Rev    : 1.0 - initial release
// ============================================================
package game_pkg;

    localparam int TARGET      = 31;
    localparam int CNT_W       = 6;
    localparam int PLAYER_W    = 3;
    localparam int NUM_PLAYERS = 6;

    localparam logic [2:0] MOVE1 = 3'b001;
    localparam logic [2:0] MOVE2 = 3'b010;
    localparam logic [2:0] MOVE3 = 3'b100;

    typedef enum logic [0:0] {
        ST_PLAY = 1'b0,
        ST_LOST = 1'b1
    } state_t;

    // Returns the amount to add; 0 flags an invalid code.
    function automatic logic [1:0] move_value(input logic [2:0] code);
        case (code)
            MOVE1:   return 2'd1;
            MOVE2:   return 2'd2;
            MOVE3:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : game_if
// Brief  : player inputs and display outputs of the game block
// Rev    : 1.0 - initial release
// ============================================================
interface game_if;
    import game_pkg::*;

    logic [2:0]             player1;
    logic [2:0]             player2;
    logic [2:0]             player3;
    logic [2:0]             player4;
    logic [2:0]             player5;
    logic [2:0]             player6;
    logic [NUM_PLAYERS-1:0] player_clk;
    logic [PLAYER_W-1:0]    out;
    logic [3:0]             state_out;

    modport master (
        output player1, player2, player3, player4, player5, player6, player_clk,
        input  out, state_out
    );

    modport slave (
        input  player1, player2, player3, player4, player5, player6, player_clk,
        output out, state_out
    );

endinterface
`default_nettype wire

// File: rtl/btn_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : btn_edge
// Brief  : 2-flop synchronizer plus rising-edge detector
// Rev    : 1.0 - initial release
// ============================================================
module btn_edge #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_press
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sync_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync1  <= i_btn;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // One-cycle pulse per press, however long the button is held.
    assign o_press = r_sync2 & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/game.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : game
// Brief  : six-player "count to 31" turn controller
// Rev    : 1.0 - initial release
// ============================================================
module game #(
    parameter int TARGET = game_pkg::TARGET,
    parameter int CNT_W  = game_pkg::CNT_W
) (
    input  logic   clk,
    input  logic   reset_n,
    game_if.slave  bus
);
    import game_pkg::*;

    logic [NUM_PLAYERS-1:0] w_press;
    logic [2:0]             w_code;
    logic                   w_active_press;
    logic [1:0]             w_n;
    logic [CNT_W-1:0]       w_sum;
    logic [PLAYER_W-1:0]    w_turn_inc;
    logic                   w_move_ok;

    state_t                 r_state,     w_state_nxt;
    logic [CNT_W-1:0]       r_total,     w_total_nxt;
    logic [PLAYER_W-1:0]    r_turn,      w_turn_nxt;
    logic [PLAYER_W-1:0]    r_out,       w_out_nxt;
    logic [3:0]             r_state_out, w_state_out_nxt;

    btn_edge #(
        .WIDTH (NUM_PLAYERS)
    ) u_btn_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (bus.player_clk),
        .o_press (w_press)
    );

    // Only the active player's code and button are ever looked at.
    always_comb begin
        w_code         = 3'b000;
        w_active_press = 1'b0;
        case (r_turn)
            3'd1: begin w_code = bus.player1; w_active_press = w_press[0]; end
            3'd2: begin w_code = bus.player2; w_active_press = w_press[1]; end
            3'd3: begin w_code = bus.player3; w_active_press = w_press[2]; end
            3'd4: begin w_code = bus.player4; w_active_press = w_press[3]; end
            3'd5: begin w_code = bus.player5; w_active_press = w_press[4]; end
            3'd6: begin w_code = bus.player6; w_active_press = w_press[5]; end
            default: begin w_code = 3'b000; w_active_press = 1'b0; end
        endcase
    end

    assign w_n        = move_value(w_code);
    assign w_sum      = r_total + {{(CNT_W-2){1'b0}}, w_n};
    assign w_turn_inc = (r_turn == PLAYER_W'(NUM_PLAYERS)) ? PLAYER_W'(1) : r_turn + PLAYER_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_total_nxt     = r_total;
        w_turn_nxt      = r_turn;
        w_out_nxt       = r_out;
        w_state_out_nxt = r_state_out;
        w_move_ok       = w_active_press && (w_n != 2'd0);
        case (r_state)
            ST_PLAY: begin
                if (w_move_ok) begin
                    if (w_sum >= CNT_W'(TARGET)) begin
                        w_state_nxt     = ST_LOST;
                        w_total_nxt     = CNT_W'(TARGET);
                        w_out_nxt       = r_turn;
                        w_state_out_nxt = {1'b1, r_turn};
                    end else begin
                        w_total_nxt     = w_sum;
                        w_turn_nxt      = w_turn_inc;
                        w_state_out_nxt = {1'b0, w_turn_inc};
                    end
                end
            end
            ST_LOST: begin
                w_state_nxt = ST_LOST;
            end
            default: begin
                w_state_nxt = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_PLAY;
            r_total     <= '0;
            r_turn      <= PLAYER_W'(1);
            r_out       <= '0;
            r_state_out <= 4'b0001;
        end else begin
            r_state     <= w_state_nxt;
            r_total     <= w_total_nxt;
            r_turn      <= w_turn_nxt;
            r_out       <= w_out_nxt;
            r_state_out <= w_state_out_nxt;
        end
    end

    assign bus.out       = r_out;
    assign bus.state_out = r_state_out;

endmodule
`default_nettype wire

// File: tb/tb_game.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : tb_game
// Brief  : self-checking bench for the game controller
// Rev    : 1.0 - initial release
// ============================================================
module tb_game;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    game_if bus ();

    game #(
        .TARGET (31),
        .CNT_W  (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] so;
        logic [2:0] out;
        int         total;
    } exp_t;

    typedef struct {
        int         player;
        logic [2:0] code;
        logic [3:0] so;
        logic [2:0] out;
        int         total;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       tbl[11];
    int         errors = 0;
    int         checks = 0;
    int         m_total;
    int         m_turn;
    bit         m_lost;
    logic [2:0] codes[1:6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_code(input int p, input logic [2:0] c);
        codes[p] = c;
        case (p)
            1: bus.player1 = c;
            2: bus.player2 = c;
            3: bus.player3 = c;
            4: bus.player4 = c;
            5: bus.player5 = c;
            default: bus.player6 = c;
        endcase
    endtask

    function automatic int mv(input logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return 0;
        endcase
    endfunction

    task automatic model_press(input logic [5:0] btns);
        int n;
        if (!m_lost && btns[m_turn-1]) begin
            n = mv(codes[m_turn]);
            if (n != 0) begin
                if (m_total + n >= 31) begin
                    m_lost  = 1'b1;
                    m_total = 31;
                end else begin
                    m_total = m_total + n;
                    m_turn  = (m_turn == 6) ? 1 : m_turn + 1;
                end
            end
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.so    = {m_lost, 3'(m_turn)};
        e.out   = m_lost ? 3'(m_turn) : 3'd0;
        e.total = m_total;
        sb_q.push_back(e);
    endtask

    // Button high for 'hold' cycles, then idle long enough for the move to land.
    task automatic pulse(input logic [5:0] btns, input int hold);
        @(negedge clk);
        bus.player_clk = btns;
        repeat (hold) @(negedge clk);
        bus.player_clk = 6'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty scoreboard expected entry", name);
        end else begin
            e = sb_q.pop_front();
            check({name, "_so"},    32'(bus.state_out), 32'(e.so));
            check({name, "_out"},   32'(bus.out),       32'(e.out));
            check({name, "_total"}, 32'(dut.r_total),   32'(e.total));
        end
    endtask

    task automatic do_move(input string name, input logic [5:0] btns, input int hold);
        model_press(btns);
        push_model();
        pulse(btns, hold);
        check_pop(name);
    endtask

    task automatic do_reset();
        bus.player_clk = 6'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_total = 0;
        m_turn  = 1;
        m_lost  = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        check({name, "_so"},    32'(bus.state_out), 32'd1);
        check({name, "_out"},   32'(bus.out),       32'd0);
        check({name, "_total"}, 32'(dut.r_total),   32'd0);
    endtask

    initial begin
        tbl[0]  = '{1, 3'b100, 4'b0010, 3'd0,  3};
        tbl[1]  = '{2, 3'b100, 4'b0011, 3'd0,  6};
        tbl[2]  = '{3, 3'b100, 4'b0100, 3'd0,  9};
        tbl[3]  = '{4, 3'b100, 4'b0101, 3'd0, 12};
        tbl[4]  = '{5, 3'b100, 4'b0110, 3'd0, 15};
        tbl[5]  = '{6, 3'b100, 4'b0001, 3'd0, 18};
        tbl[6]  = '{1, 3'b100, 4'b0010, 3'd0, 21};
        tbl[7]  = '{2, 3'b100, 4'b0011, 3'd0, 24};
        tbl[8]  = '{3, 3'b100, 4'b0100, 3'd0, 27};
        tbl[9]  = '{4, 3'b100, 4'b0101, 3'd0, 30};
        tbl[10] = '{5, 3'b100, 4'b1101, 3'd5, 31};

        bus.player_clk = 6'b0;
        for (int p = 1; p <= 6; p++) set_code(p, 3'b000);

        do_reset();
        check_reset("reset");

        // Exact latency: no change after the 2nd edge, new value after the 3rd.
        set_code(1, 3'b100);
        model_press(6'b000001);
        @(negedge clk);
        bus.player_clk = 6'b000001;
        @(posedge clk);
        @(negedge clk);
        bus.player_clk = 6'b0;
        @(posedge clk);
        #1 check("lat_e2_so", 32'(bus.state_out), 32'd1);
        @(posedge clk);
        #1 check("lat_e3_so", 32'(bus.state_out), 32'b0010);
        check("lat_e3_total", 32'(dut.r_total), 32'd3);
        check("lat_e3_out", 32'(bus.out), 32'd0);
        repeat (3) @(negedge clk);

        do_move("p1_again", 6'b000001, 1);
        do_move("p1_again2", 6'b000001, 3);

        // Full game from the table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            exp_t e;
            set_code(tbl[i].player, tbl[i].code);
            model_press(6'(1 << (tbl[i].player - 1)));
            e.so    = tbl[i].so;
            e.out   = tbl[i].out;
            e.total = tbl[i].total;
            sb_q.push_back(e);
            pulse(6'(1 << (tbl[i].player - 1)), 1);
            check_pop($sformatf("game_m%0d", i + 1));
        end
        for (int b = 0; b < 6; b++) do_move($sformatf("lost_btn%0d", b), 6'(1 << b), 1);
        do_move("lost_all", 6'b111111, 1);

        do_reset();
        check_reset("reset_after_loss");

        // Invalid codes are ignored, a valid one then advances.
        set_code(1, 3'b011);
        do_move("inv_011", 6'b000001, 1);
        set_code(1, 3'b000);
        do_move("inv_000", 6'b000001, 1);
        set_code(1, 3'b001);
        do_move("valid_001", 6'b000001, 1);

        // Held button gives one move only.
        set_code(2, 3'b010);
        do_move("hold_p2", 6'b000010, 8);

        // Off-turn press, then simultaneous presses.
        do_reset();
        set_code(1, 3'b010);
        set_code(2, 3'b100);
        do_move("p2_offturn", 6'b000010, 1);
        do_move("p1p2_simul", 6'b000011, 1);

        // Mid-game reset after four moves.
        do_reset();
        for (int p = 1; p <= 4; p++) begin
            set_code(p, 3'b001);
            do_move($sformatf("mid_m%0d", p), 6'(1 << (p - 1)), 1);
        end
        do_reset();
        check_reset("reset_mid");
        set_code(1, 3'b010);
        do_move("after_mid", 6'b000001, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
